// File: rtl/led_scan_if.sv
// Control/status bundle between the board push-buttons and the LED scan sequencer.
// Build option LED_SCAN_PWM_DIM_EN adds the 4-bit duty input.
interface led_scan_if;
  logic       next_btn;
  logic       mode_btn;
  logic       enable;
  logic [2:0] select;
  logic       led_status;
  logic       blink_tick;
  logic [1:0] mode;
`ifdef LED_SCAN_PWM_DIM_EN
  logic [3:0] duty;

  modport master (output next_btn, mode_btn, enable, duty,
                  input  select, led_status, blink_tick, mode);
  modport slave  (input  next_btn, mode_btn, enable, duty,
                  output select, led_status, blink_tick, mode);
`else
  modport master (output next_btn, mode_btn, enable,
                  input  select, led_status, blink_tick, mode);
  modport slave  (input  next_btn, mode_btn, enable,
                  output select, led_status, blink_tick, mode);
`endif
endinterface

// File: rtl/led_scan_sequencer.sv
// LED scan sequencer: debounced buttons, blink prescaler, MANUAL/AUTO_UP/PING_PONG select stepping.
// Build option LED_SCAN_PWM_DIM_EN adds PWM dimming of led_status via bus.duty.
module led_scan_sequencer #(
  parameter int BLINK_DIV       = 25000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DWELL_BLINKS    = 4
) (
  input logic       clk,
  input logic       rst_n,
  led_scan_if.slave bus
);

  localparam int PW  = $clog2(BLINK_DIV);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DWW = $clog2(DWELL_BLINKS + 1);

  typedef enum logic [1:0] {MANUAL = 2'd0, AUTO_UP = 2'd1, PING_PONG = 2'd2} mode_e;

  // Returns {down, select} after one step under the given mode's rule.
  function automatic logic [3:0] step_sel(input mode_e m, input logic [2:0] s, input logic down);
    logic [2:0] ns;
    logic       nd;
    ns = s + 3'd1;
    nd = down;
    if (m == PING_PONG) begin
      if (!down) begin
        if (s == 3'd7) begin ns = 3'd6; nd = 1'b1; end
        else           begin ns = s + 3'd1; nd = (s == 3'd6); end
      end else begin
        if (s == 3'd0) begin ns = 3'd1; nd = 1'b0; end
        else           begin ns = s - 3'd1; nd = (s != 3'd1); end
      end
    end
    return {nd, ns};
  endfunction

  logic [1:0]     btn_raw, btn_p0, btn_p1, btn_lvl, btn_press;
  logic [DBW-1:0] db_cnt [2];
  logic           next_press, mode_press;

  assign btn_raw    = {bus.mode_btn, bus.next_btn};
  assign next_press = btn_press[0];
  assign mode_press = btn_press[1];

  // Stage p0/p1: two-flop synchroniser, then per-button debounce and rising-edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0    <= '0;
      btn_p1    <= '0;
      btn_lvl   <= '0;
      btn_press <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      btn_p0 <= btn_raw;
      btn_p1 <= btn_p0;
      for (int i = 0; i < 2; i++) begin
        btn_press[i] <= 1'b0;
        if (btn_p1[i] == btn_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i]    <= '0;
          btn_lvl[i]   <= btn_p1[i];
          btn_press[i] <= btn_p1[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  mode_e mode_q, mode_n;
  logic  is_auto;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= MANUAL;
    else        mode_q <= mode_n;
  end

  always_comb begin
    mode_n = mode_q;
    if (mode_press) begin
      case (mode_q)
        MANUAL:  mode_n = AUTO_UP;
        AUTO_UP: mode_n = PING_PONG;
        default: mode_n = MANUAL;
      endcase
    end
  end

  always_comb begin
    is_auto = (mode_q != MANUAL);
  end

  logic [PW-1:0]  presc_q, presc_n;
  logic [DWW-1:0] dwell_q, dwell_n;
  logic [2:0]     sel_q, sel_n;
  logic           blink_q, blink_n, tick_q, tick_n, down_q, down_n, run_q, run_n;
  logic           wrap, advance;
  logic [3:0]     step;

  // run_q low means the previous cycle was disabled, so the next enabled cycle restarts the blink
  always_comb begin
    presc_n = presc_q;
    dwell_n = dwell_q;
    blink_n = blink_q;
    tick_n  = 1'b0;
    sel_n   = sel_q;
    down_n  = down_q;
    run_n   = run_q;
    advance = 1'b0;
    wrap    = (presc_q == PW'(BLINK_DIV - 1));
    step    = step_sel(mode_q, sel_q, down_q);
    if (mode_press) begin
      presc_n = '0;
      dwell_n = '0;
      blink_n = bus.enable;
      down_n  = 1'b0;
      run_n   = bus.enable;
    end else if (!bus.enable) begin
      presc_n = '0;
      dwell_n = '0;
      blink_n = 1'b0;
      run_n   = 1'b0;
    end else if (next_press && is_auto) begin
      {down_n, sel_n} = step;
      presc_n = '0;
      dwell_n = '0;
      blink_n = 1'b1;
      run_n   = 1'b1;
    end else begin
      if (!run_q) begin
        presc_n = '0;
        dwell_n = '0;
        blink_n = 1'b1;
        run_n   = 1'b1;
      end else if (wrap) begin
        presc_n = '0;
        blink_n = ~blink_q;
        tick_n  = 1'b1;
        if (!blink_q) begin
          if (dwell_q == DWW'(DWELL_BLINKS - 1)) begin
            dwell_n = '0;
            advance = 1'b1;
          end else begin
            dwell_n = dwell_q + DWW'(1);
          end
        end
      end else begin
        presc_n = presc_q + PW'(1);
      end
      if (is_auto ? advance : next_press) {down_n, sel_n} = step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      dwell_q <= '0;
      sel_q   <= 3'd0;
      blink_q <= 1'b1;
      tick_q  <= 1'b0;
      down_q  <= 1'b0;
      run_q   <= 1'b1;
    end else begin
      presc_q <= presc_n;
      dwell_q <= dwell_n;
      sel_q   <= sel_n;
      blink_q <= blink_n;
      tick_q  <= tick_n;
      down_q  <= down_n;
      run_q   <= run_n;
    end
  end

`ifdef LED_SCAN_PWM_DIM_EN
  logic [3:0] pwm_cnt_q;
  logic       led_q, pwm_on;

  assign pwm_on = (pwm_cnt_q < bus.duty) || (bus.duty == 4'hF);

  // Dimmed output registered from the next blink value so it stays aligned with blink_tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= 4'd0;
      led_q     <= 1'b1;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      led_q     <= blink_n & pwm_on;
    end
  end

  assign bus.led_status = led_q;
`else
  assign bus.led_status = blink_q;
`endif

  assign bus.select     = sel_q;
  assign bus.blink_tick = tick_q;
  assign bus.mode       = logic'(mode_q[1]) ? 2'd2 : {1'b0, mode_q[0]};

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Randomised and directed bench for led_scan_sequencer against a time-based behavioural model.
// Model: blink phase and dwell advances derived from cycles elapsed since the last restart.
module tb_led_scan_sequencer;
  localparam int BLINK_DIV       = 4;
  localparam int DEBOUNCE_CYCLES = 3;
  localparam int DWELL_BLINKS    = 2;
  localparam int DWELL_T   = 2 * BLINK_DIV * DWELL_BLINKS;
  localparam int PRESS_LAT = 2 + DEBOUNCE_CYCLES + 1;
  localparam int BTN_SPAN  = 2 * PRESS_LAT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  led_scan_if bus ();

  led_scan_sequencer #(
    .BLINK_DIV(BLINK_DIV), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DWELL_BLINKS(DWELL_BLINKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: t = cycles since the last restart of the blink
  int m_mode, m_sel, m_t;
  bit m_down, m_run;
  int nxt_ph, md_ph;
  bit en_drv, bnc;

  function automatic bit exp_led();
    return m_run && ((m_t / BLINK_DIV) % 2 == 0);
  endfunction

  function automatic bit exp_tick();
    return m_run && (m_t > 0) && (m_t % BLINK_DIV == 0);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_t = 0; m_down = 0; m_run = 1;
    nxt_ph = 0; md_ph = 0; bnc = 0;
  endtask

  task automatic model_advance();
    if (m_mode == 1) begin
      m_sel = (m_sel + 1) % 8;
    end else if (!m_down) begin
      if (m_sel == 7) begin m_sel = 6; m_down = 1; end
      else begin m_sel = m_sel + 1; m_down = (m_sel == 7); end
    end else begin
      if (m_sel == 0) begin m_sel = 1; m_down = 0; end
      else begin m_sel = m_sel - 1; m_down = (m_sel != 0); end
    end
  endtask

  task automatic model_step(input bit nxt, input bit md, input bit en);
    if (md) begin
      m_mode = (m_mode + 1) % 3; m_t = 0; m_run = en; m_down = 0;
    end else if (!en) begin
      m_run = 0; m_t = 0;
    end else if (nxt && m_mode != 0) begin
      model_advance(); m_t = 0; m_run = 1;
    end else begin
      if (!m_run) begin
        m_run = 1; m_t = 0;
      end else begin
        m_t++;
        if (m_mode != 0 && m_t % DWELL_T == 0) model_advance();
      end
      if (m_mode == 0 && nxt) m_sel = (m_sel + 1) % 8;
    end
  endtask

  // One clock: drive inputs on the falling edge, update the model at the rising edge, sample 1 later
  task automatic cyc();
    bit nxt_ev, md_ev;
    @(negedge clk);
    bus.next_btn = (nxt_ph > PRESS_LAT) | bnc;
    bus.mode_btn = (md_ph > PRESS_LAT);
    bus.enable   = en_drv;
    @(posedge clk);
    nxt_ev = (nxt_ph == PRESS_LAT + 1);
    md_ev  = (md_ph == PRESS_LAT + 1);
    if (nxt_ph > 0) nxt_ph--;
    if (md_ph > 0) md_ph--;
    model_step(nxt_ev, md_ev, en_drv);
    #1;
  endtask

  task automatic start_press(input bit n, input bit m);
    if (n) nxt_ph = BTN_SPAN;
    if (m) md_ph = BTN_SPAN;
  endtask

  task automatic settle();
    for (int k = 0; k < BTN_SPAN + 2 && (nxt_ph != 0 || md_ph != 0); k++) cyc();
  endtask

  task automatic test_reset();
    bus.next_btn = 0; bus.mode_btn = 0; bus.enable = 1; en_drv = 1;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.select !== 3'd0) begin errors++; $display("FAIL reset_select got=%0d want=0", bus.select); end
    checks++; if (bus.led_status !== 1'b1) begin errors++; $display("FAIL reset_led got=%b want=1", bus.led_status); end
    checks++; if (bus.blink_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b want=0", bus.blink_tick); end
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL reset_mode got=%0d want=0", bus.mode); end
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_manual_blink();
    int ticks = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (bus.blink_tick === 1'b1) ticks++;
      checks++; if (bus.select !== 3'(m_sel)) begin errors++; $display("FAIL blink_select cyc=%0d got=%0d want=%0d", k, bus.select, m_sel); end
      checks++; if (bus.led_status !== exp_led()) begin errors++; $display("FAIL blink_led cyc=%0d got=%b want=%b", k, bus.led_status, exp_led()); end
      checks++; if (bus.blink_tick !== exp_tick()) begin errors++; $display("FAIL blink_tick cyc=%0d got=%b want=%b", k, bus.blink_tick, exp_tick()); end
    end
    checks++; if (ticks != 20 / BLINK_DIV) begin errors++; $display("FAIL blink_tick_count got=%0d want=%0d", ticks, 20 / BLINK_DIV); end
  endtask

  task automatic test_manual_next();
    for (int i = 0; i < 9; i++) begin
      start_press(1, 0);
      settle();
      checks++; if (bus.select !== 3'((i + 1) % 8)) begin errors++; $display("FAIL manual_next press=%0d got=%0d want=%0d", i, bus.select, (i + 1) % 8); end
      checks++; if (bus.select !== 3'(m_sel)) begin errors++; $display("FAIL manual_next_model press=%0d got=%0d want=%0d", i, bus.select, m_sel); end
    end
  endtask

  task automatic test_bounce();
    bit pat [4] = '{1, 0, 1, 0};
    for (int k = 0; k < 14; k++) begin
      bnc = (k < 4) ? pat[k] : 1'b0;
      cyc();
    end
    checks++; if (bus.select !== 3'd1) begin errors++; $display("FAIL bounce_select got=%0d want=1", bus.select); end
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL bounce_mode got=%0d want=0", bus.mode); end
    for (int i = 0; i < 8 && m_sel != 0; i++) begin
      start_press(1, 0);
      settle();
    end
  endtask

  task automatic test_auto_up();
    start_press(0, 1);
    for (int k = 0; k < 20 && m_mode != 1; k++) cyc();
    checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL auto_mode got=%0d want=1", bus.mode); end
    for (int k = 1; k <= 56; k++) begin
      cyc();
      checks++; if (bus.select !== 3'(m_sel)) begin errors++; $display("FAIL auto_select cyc=%0d got=%0d want=%0d", k, bus.select, m_sel); end
      checks++; if (bus.led_status !== exp_led()) begin errors++; $display("FAIL auto_led cyc=%0d got=%b want=%b", k, bus.led_status, exp_led()); end
    end
    checks++; if (bus.select !== 3'd3) begin errors++; $display("FAIL auto_final got=%0d want=3", bus.select); end
  endtask

  task automatic test_ping_pong();
    int seq[$];
    int want [4] = '{6, 7, 6, 5};
    start_press(0, 1); settle();
    start_press(0, 1); settle();
    for (int i = 0; i < 8 && m_sel != 6; i++) begin start_press(1, 0); settle(); end
    start_press(0, 1); settle();
    start_press(0, 1);
    for (int k = 0; k < 20 && m_mode != 2; k++) cyc();
    checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL pp_mode got=%0d want=2", bus.mode); end
    seq.push_back(int'(bus.select));
    for (int k = 1; k <= 50; k++) begin
      cyc();
      if (int'(bus.select) != seq[$]) seq.push_back(int'(bus.select));
      checks++; if (bus.select !== 3'(m_sel)) begin errors++; $display("FAIL pp_select cyc=%0d got=%0d want=%0d", k, bus.select, m_sel); end
    end
    checks++; if (seq.size() != 4) begin errors++; $display("FAIL pp_len got=%0d want=4", seq.size()); end
    for (int i = 0; i < 4 && i < seq.size(); i++) begin
      checks++; if (seq[i] != want[i]) begin errors++; $display("FAIL pp_seq idx=%0d got=%0d want=%0d", i, seq[i], want[i]); end
    end
  endtask

  task automatic test_simultaneous();
    start_press(0, 1); settle();
    for (int i = 0; i < 8 && m_sel != 3; i++) begin start_press(1, 0); settle(); end
    checks++; if (bus.mode !== 2'd0 || bus.select !== 3'd3) begin errors++; $display("FAIL simul_setup mode=%0d sel=%0d want mode=0 sel=3", bus.mode, bus.select); end
    start_press(1, 1); settle();
    checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL simul_mode got=%0d want=1", bus.mode); end
    checks++; if (bus.select !== 3'd3) begin errors++; $display("FAIL simul_select got=%0d want=3", bus.select); end
  endtask

  task automatic test_enable();
    int frozen = m_sel;
    en_drv = 0;
    start_press(1, 0);
    for (int k = 0; k < 30; k++) begin
      cyc();
      checks++; if (bus.select !== 3'(frozen)) begin errors++; $display("FAIL dis_select cyc=%0d got=%0d want=%0d", k, bus.select, frozen); end
      checks++; if (bus.led_status !== 1'b0 || bus.blink_tick !== 1'b0) begin errors++; $display("FAIL dis_led cyc=%0d led=%b tick=%b want 0 0", k, bus.led_status, bus.blink_tick); end
    end
    en_drv = 1;
    cyc();
    checks++; if (bus.led_status !== 1'b1) begin errors++; $display("FAIL reen_led got=%b want=1", bus.led_status); end
    for (int k = 1; k <= 16; k++) begin
      cyc();
      checks++;
      if (bus.select !== 3'((k < 16) ? frozen : (frozen + 1) % 8)) begin
        errors++; $display("FAIL reen_select cyc=%0d got=%0d want=%0d", k, bus.select, (k < 16) ? frozen : (frozen + 1) % 8);
      end
    end
  endtask

  task automatic test_random();
    int op, n;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 6);
      n = BTN_SPAN;
      case (op)
        0, 1: n = $urandom_range(1, 24);
        2, 3: start_press(1, 0);
        4:    start_press(0, 1);
        5:    start_press(1, 1);
        default: begin en_drv = ~en_drv; n = $urandom_range(1, 6); end
      endcase
      for (int k = 0; k < n; k++) begin
        cyc();
        checks++; if (bus.select !== 3'(m_sel)) begin errors++; $display("FAIL rnd_select it=%0d got=%0d want=%0d", it, bus.select, m_sel); end
        checks++; if (bus.mode !== 2'(m_mode)) begin errors++; $display("FAIL rnd_mode it=%0d got=%0d want=%0d", it, bus.mode, m_mode); end
        checks++; if (bus.led_status !== exp_led()) begin errors++; $display("FAIL rnd_led it=%0d got=%b want=%b", it, bus.led_status, exp_led()); end
        checks++; if (bus.blink_tick !== exp_tick()) begin errors++; $display("FAIL rnd_tick it=%0d got=%b want=%b", it, bus.blink_tick, exp_tick()); end
      end
    end
    en_drv = 1;
    settle();
  endtask

  task automatic test_async_reset();
    if (m_mode == 0) begin start_press(0, 1); settle(); end
    if (m_sel == 0) begin start_press(1, 0); settle(); end
    cyc();
    #2;
    rst_n = 0;
    #1;
    checks++; if (bus.select !== 3'd0) begin errors++; $display("FAIL areset_select got=%0d want=0", bus.select); end
    checks++; if (bus.led_status !== 1'b1) begin errors++; $display("FAIL areset_led got=%b want=1", bus.led_status); end
    checks++; if (bus.blink_tick !== 1'b0) begin errors++; $display("FAIL areset_tick got=%b want=0", bus.blink_tick); end
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL areset_mode got=%0d want=0", bus.mode); end
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

`ifdef LED_SCAN_PWM_DIM_EN
  initial bus.duty = 4'hF;
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_manual_blink();
    test_manual_next();
    test_bounce();
    test_auto_up();
    test_ping_pong();
    test_simultaneous();
    test_enable();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_scan_sequencer.md
Name: led_scan_sequencer

Overview:
- Controller for the 8-LED blink datapath: drives the 3-bit LED select and the blink data bit that feed the 3-to-8 LED demux.
- Replaces the raw button-clocked select register with a fully synchronous design: synchronised, debounced buttons; blink prescaler; three scan modes.
- Sits between the board clock/push-buttons and the demux.

Parameters:
- BLINK_DIV, 25000000, clk cycles per blink half-period; min 2.
- DEBOUNCE_CYCLES, 1000000, cycles a synchronised button level must stay stable before acceptance; min 1.
- DWELL_BLINKS, 4, full blink periods spent on each LED in auto modes; min 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- next_btn  in  1  raw push-button, active-high, asynchronous to clk.
- mode_btn  in  1  raw push-button, active-high, asynchronous to clk.
- enable  in  1  run enable, synchronous.
- select  out  3  LED index to the demux.
- led_status  out  1  blink data bit to the demux.
- blink_tick  out  1  one-cycle pulse at every led_status toggle.
- mode  out  2  current mode: 0 MANUAL, 1 AUTO_UP, 2 PING_PONG.

Behaviour:
- Reset (async assert, sync use after release):
  - select=0, led_status=1, blink_tick=0, mode=0 (MANUAL).
  - Prescaler=0, dwell=0, ping-pong direction=up.
  - Debouncers cleared to released.
- Button path, per button:
  - 2-flop synchroniser, then a debounce counter.
  - Accepted level updates only after DEBOUNCE_CYCLES consecutive cycles at the new level; any bounce restarts the count.
  - Rising edge of the accepted level produces a one-cycle press pulse.
  - Worst-case latency from raw edge to pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Prescaler (while enable=1):
  - Counts 0..BLINK_DIV-1.
  - On wrap: toggle led_status and pulse blink_tick in the same cycle.
- Dwell counter:
  - Increments on each blink_tick that drives led_status 0->1, i.e. one full period.
  - Reaching DWELL_BLINKS raises an advance event and clears the counter.
- Mode FSM:
  - mode press steps MANUAL -> AUTO_UP -> PING_PONG -> MANUAL.
  - On a mode change: select is kept, dwell=0, prescaler=0, led_status=1, direction=up.
- MANUAL:
  - next press: select <= select+1, wrapping 7->0.
  - Dwell events are ignored.
- AUTO_UP:
  - Advance event: select+1, wrapping 7->0.
- PING_PONG:
  - Direction up: select+1; at 7 the direction becomes down.
  - Direction down: select-1; at 0 the direction becomes up.
  - Endpoints are visited once per turn (sequence ...6,7,6...).
- next press in an auto mode:
  - Immediate advance by the same rule as the mode.
  - Clears dwell and prescaler; led_status=1.
- Simultaneous events:
  - mode press wins over next press and over the dwell advance in the same cycle; the other events are dropped.
  - next press coinciding with a dwell advance gives one step only.
- enable=0:
  - Prescaler and dwell held at 0; led_status forced 0; blink_tick=0.
  - select frozen; next presses dropped.
  - mode presses still accepted.
  - Re-enable restarts with led_status=1 and prescaler=0.
- All outputs are registered; a select change is visible the cycle after the event.

Optional Feature:
- Macro: LED_SCAN_PWM_DIM_EN.
- Defined:
  - Adds input port duty, 4 bits.
  - A free-running 4-bit PWM counter; pwm_on = (pwm_cnt < duty) OR (duty == 15).
  - led_status output = internal blink bit AND pwm_on, registered.
  - duty=0 keeps the LED dark.
  - blink_tick, dwell and select timing are unchanged.
- Undefined: no duty port; led_status = internal blink bit.

Test Plan (BLINK_DIV=4, DEBOUNCE_CYCLES=3, DWELL_BLINKS=2):
- Reset then run 20 cycles in MANUAL, no buttons -> select=0, led_status toggles every 4 cycles, blink_tick pulses every 4 cycles.
- MANUAL, 9 clean next presses -> select 1,2,...,7,0,1; next pulse bouncing 1-0-1 within 2 cycles -> no advance.
- One mode press (AUTO_UP), run 56 cycles -> select advances every 16 cycles: 0->1->2->3.
- Two mode presses (PING_PONG) starting at select=6 -> sequence 6,7,6,5, one step per 16 cycles.
- mode and next presses accepted in the same cycle in MANUAL, select=3 -> mode=1, select stays 3.
- enable=0 for 30 cycles in AUTO_UP -> select frozen, led_status=0; re-enable -> led_status=1 the next cycle, first advance 16 cycles later. Assert rst_n mid-run -> all outputs at reset values immediately, without waiting for a clock edge.
